mod_mul_pipe: RTL and testbench

//  Pipelined Dilithium modular multiplier: out = (a*b) mod q, q = 8380417.

---
 rtl/mod_mul_pipe_pkg.sv | 14 +
 rtl/mod_mul_pipe_dred.sv | 31 +++
 rtl/mod_mul_pipe.sv | 126 ++++++++++++
 tb/tb_mod_mul_pipe.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_mul_pipe_pkg.sv
// Shared constants for the Dilithium modular-multiplier pipeline.
//   DIL_Q   Dilithium modulus q = 2^23 - 2^13 + 1
//   DIL_W   width of a residue mod q
//   PROD_W  width of the full unsigned product of two residues
//   FOLD_K  q = 2^DIL_W - 2^FOLD_K + 1, so 2^DIL_W == 2^FOLD_K - 1 (mod q)
package mod_mul_pipe_pkg;

    localparam int DIL_W  = 23;
    localparam int PROD_W = 46;
    localparam int FOLD_K = 13;

    localparam logic [DIL_W-1:0] DIL_Q = 23'd8380417;

endpackage

// File: rtl/mod_mul_pipe_dred.sv
// DRed: combinational reduction of a 46-bit unsigned product modulo q = 8380417.
//   p    in   46   product to reduce
//   out  out  23   p mod q, always in [0, q-1] for any 46-bit p
// Each fold replaces hi*2^23 by hi*(2^13 - 1), which is congruent mod q.
// Three folds bring any 46-bit value below 2*q, so one conditional
// subtraction yields the canonical residue.
module mod_mul_pipe_dred
    import mod_mul_pipe_pkg::*;
(
    input  logic [PROD_W-1:0] p,
    output logic [DIL_W-1:0]  out
);

    // Bounds: t1 < 2^37, t2 < 2^27 + 2^23, t3 < 2^23 + 17*8191 < 2*q.
    logic [36:0] t1;
    logic [27:0] t2;
    logic [23:0] t3;

    // NOTE: every signal written in an always_comb block is assigned on every
    // path; a missing assignment would infer a latch.
    always_comb begin
        t1  = ({14'd0, p[45:23]} << FOLD_K) - {14'd0, p[45:23]} + {14'd0, p[22:0]};
        t2  = ({14'd0, t1[36:23]} << FOLD_K) - {14'd0, t1[36:23]} + {5'd0, t1[22:0]};
        t3  = ({19'd0, t2[27:23]} << FOLD_K) - {19'd0, t2[27:23]} + {1'b0, t2[22:0]};
        out = t3[22:0];
        if (t3 >= {1'b0, DIL_Q}) begin
            out = t3[22:0] - DIL_Q;
        end
    end

endmodule

// File: rtl/mod_mul_pipe.sv
// Three-stage pipelined modular multiplier: res = (a*b) mod 8380417.
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_ready depends combinationally on out_ready
//   a, b, in_tag          operands (expected < Q) and sideband tag
//   out_valid/out_ready   result handshake
//   res, out_tag          reduced product and its tag, held stable while stalled
//   busy                  some stage holds a valid entry
//   range_err, err_clr    sticky flag for an accepted operand >= Q; err_clr clears it
// S1 registers {a,b,tag}, S2 registers the 46-bit product, S3 registers DRed(product).
// Each stage loads when empty or when its entry leaves in the same cycle, so
// bubbles collapse and a full pipe still streams one result per cycle.
module mod_mul_pipe
    import mod_mul_pipe_pkg::*;
#(
    parameter int               TAG_W = 4,
    parameter logic [DIL_W-1:0] Q     = DIL_Q
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIL_W-1:0] a,
    input  logic [DIL_W-1:0] b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DIL_W-1:0] res,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic             range_err,
    input  logic             err_clr
);

    // S1 data holds {a, b}; S2 data holds the product. Both are PROD_W wide.
    typedef struct packed {
        logic              v;
        logic [PROD_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } stage_t;

    typedef struct packed {
        logic              v;
        logic [DIL_W-1:0]  data;
        logic [TAG_W-1:0]  tag;
    } res_stage_t;

    stage_t     s1, s2;
    res_stage_t s3;

    // Held low through reset and for the first cycle after release.
    logic rdy_en;

    logic s1_ready, s2_ready, s3_ready;
    logic in_fire, bad_op;
    logic [PROD_W-1:0] prod;
    logic [DIL_W-1:0]  dred_out;

    // A stage can take a new entry if it is empty or its entry moves on now.
    assign s3_ready = !s3.v || out_ready;
    assign s2_ready = !s2.v || s3_ready;
    assign s1_ready = !s1.v || s2_ready;

    assign in_ready = rdy_en && s1_ready;
    assign in_fire  = in_valid && in_ready;
    assign bad_op   = (a >= Q) || (b >= Q);

    assign prod = PROD_W'(s1.data[PROD_W-1:DIL_W]) * PROD_W'(s1.data[DIL_W-1:0]);

    mod_mul_pipe_dred u_dred (
        .p   (s2.data),
        .out (dred_out)
    );

    // NOTE: all state, data registers included, is cleared by the asynchronous
    // reset and updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            rdy_en    <= 1'b0;
            range_err <= 1'b0;
        end else begin
            rdy_en <= 1'b1;

            if (s1_ready) begin
                s1.v <= in_fire;
                if (in_fire) begin
                    s1.data <= {a, b};
                    s1.tag  <= in_tag;
                end
            end

            if (s2_ready) begin
                s2.v <= s1.v;
                if (s1.v) begin
                    s2.data <= prod;
                    s2.tag  <= s1.tag;
                end
            end

            // Data only changes when a valid entry arrives, so a stalled
            // result stays put.
            if (s3_ready) begin
                s3.v <= s2.v;
                if (s2.v) begin
                    s3.data <= dred_out;
                    s3.tag  <= s2.tag;
                end
            end

            // A new error outranks a simultaneous clear.
            if (in_fire && bad_op) begin
                range_err <= 1'b1;
            end else if (err_clr) begin
                range_err <= 1'b0;
            end
        end
    end

    assign out_valid = s3.v;
    assign res       = s3.data;
    assign out_tag   = s3.tag;
    assign busy      = s1.v || s2.v || s3.v;

endmodule

// File: tb/tb_mod_mul_pipe.sv
// Self-checking bench for mod_mul_pipe. A queue model holds every accepted
// operation with its expected (a*b) mod q; a negedge monitor checks the DUT
// outputs, busy and the capacity rule for in_ready against it every cycle.
module tb_mod_mul_pipe;

    localparam int          TAG_W = 4;
    localparam int unsigned QV    = 8380417;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [22:0]       a, b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [22:0]       res;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;
    logic              range_err;
    logic              err_clr;

    mod_mul_pipe #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .out_tag   (out_tag),
        .busy      (busy),
        .range_err (range_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [22:0]      res;
        logic [TAG_W-1:0] tag;
        bit               chk;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int since_rst = 0;
    int n_acc   = 0;
    int n_out   = 0;
    int acc_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [22:0] mulmod(input logic [22:0] x, input logic [22:0] y);
        logic [63:0] p;
        p = {41'd0, x} * {41'd0, y};
        return 23'(p % 64'(QV));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) since_rst <= 0;
        else if (since_rst < 1000) since_rst <= since_rst + 1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare state as seen after the last edge, then record the
    // transfers that the next edge will perform.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            check("in_ready", in_ready, (since_rst >= 1) && (exp_q.size() < 3 || out_ready));
            check("busy", busy, exp_q.size() != 0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("out_valid_unexpected", out_valid, 0);
                end else begin
                    if (exp_q[0].chk) check("res", res, exp_q[0].res);
                    check("out_tag", out_tag, exp_q[0].tag);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e.res = mulmod(a, b);
                e.tag = in_tag;
                e.chk = (a < QV) && (b < QV);
                exp_q.push_back(e);
                n_acc++;
                acc_cyc = cyc;
            end
        end
    end

    // Present one operand pair (called just after a rising edge) and hold it
    // until accepted; returns just after the accepting edge.
    task automatic send(input logic [22:0] x, input logic [22:0] y, input logic [TAG_W-1:0] t);
        int g = 0;
        a = x; b = y; in_tag = t; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid; returns at the negedge it was seen.
    task automatic wait_out(output int c);
        int g = 0;
        @(negedge clk);
        while (!out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!out_valid) check("wait_out_timeout", out_valid, 1);
        c = cyc;
    endtask

    task automatic drain();
        int g = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    function automatic logic [22:0] pick();
        int unsigned r;
        r = $urandom_range(7, 0);
        if (r == 0) return 23'd0;
        if (r == 1) return 23'(QV - 1);
        return 23'($urandom_range(QV - 1, 0));
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, n0, target;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; in_tag = '0;
        out_ready = 1'b1; err_clr = 1'b0;

        // Reset state
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_range_err", range_err, 0);
        check("rst_res", res, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_first_cycle", in_ready, 0);
        @(posedge clk); #1;
        check("in_ready_after_release", in_ready, 1);

        // Model pins
        check("model_pin_qm1", mulmod(23'(QV - 1), 23'(QV - 1)), 1);
        check("model_pin_2p23", mulmod(23'd4194304, 23'd2), 8191);

        // 1) single op, latency and single pulse
        send(23'd2, 23'd3, 4'd5);
        wait_out(c);
        check("t1_latency", c - acc_cyc, 3);
        check("t1_res", res, 6);
        check("t1_tag", out_tag, 5);
        @(negedge clk);
        check("t1_single_pulse", out_valid, 0);
        @(posedge clk); #1;

        // 2) boundary arithmetic
        send(23'd8380416, 23'd8380416, 4'd1);
        wait_out(c);
        check("t2_qm1_sq", res, 1);
        @(posedge clk); #1;
        send(23'd4194304, 23'd2, 4'd2);
        wait_out(c);
        check("t2_2p23", res, 8191);
        @(posedge clk); #1;
        send(23'd0, 23'd7654321, 4'd3);
        wait_out(c);
        check("t2_zero_a", res, 0);
        @(posedge clk); #1;
        send(23'd1234567, 23'd0, 4'd4);
        wait_out(c);
        check("t2_zero_b", res, 0);
        @(posedge clk); #1;

        // 3) backpressure: three accepts fill the pipe, fourth is held
        out_ready = 1'b0;
        n0 = n_out;
        for (int i = 0; i < 3; i++) send(pick(), pick(), 4'(i + 8));
        a = 23'd99; b = 23'd77; in_tag = 4'd11; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_full_in_ready", in_ready, 0);
            check("t3_full_out_valid", out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_shift_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        check("t3_count", n_out - n0, 4);

        // 5) range_err
        send(23'd8380417, 23'd5, 4'd6);
        check("t5_set_a", range_err, 1);
        repeat (3) @(posedge clk);
        #1 check("t5_sticky", range_err, 1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("t5_clear", range_err, 0);
        a = 23'd8380417; b = 23'd1; in_tag = 4'd7; in_valid = 1'b1; err_clr = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; err_clr = 1'b0;
        check("t5_set_wins", range_err, 1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        send(23'd1, 23'h7fffff, 4'd8);
        check("t5_set_b", range_err, 1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        send(23'(QV - 1), 23'(QV - 1), 4'd9);
        check("t5_legal_no_set", range_err, 0);
        drain();

        // 4) random stream with random stalls
        n0 = n_acc;
        target = n0 + 10000;
        for (int i = 0; i < 40000; i++) begin
            @(posedge clk); #1;
            if (n_acc >= target) break;
            in_valid  = ($urandom_range(3, 0) != 0);
            a         = pick();
            b         = pick();
            in_tag    = 4'($urandom_range(15, 0));
            case ((i / 400) % 3)
                0:       out_ready = ($urandom_range(3, 0) != 0);
                1:       out_ready = ($urandom_range(3, 0) == 0);
                default: out_ready = 1'b1;
            endcase
        end
        in_valid = 1'b0;
        check("t4_accepted", n_acc - n0, 10000);
        drain();

        // 6) reset with ops in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(pick(), pick(), 4'(i + 1));
        #2 rst_n = 1'b0;
        #1;
        check("t6_out_valid", out_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_res", res, 0);
        check("t6_out_tag", out_tag, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t6_no_stale", out_valid, 0);
        end
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
